energy_manager: RTL

Battery/energy controller for the smart air conditioner. It holds the battery level and arbitrates between charging and running. Charging is only allowed while the unit is off. The block enables and resets the keypad charge-entry unit, commits the entered amount into the battery, and drains the battery at a load-dependent rate while the unit is on. When the battery is empty it forces power-off.

---
 rtl/energy_pkg.sv | 28 ++
 rtl/energy_manager_tick_gen.sv | 32 +++
 rtl/energy_manager.sv | 121 ++++++++++++
 3 files changed

// File: rtl/energy_pkg.sv
// Shared types and constants for the air-conditioner energy manager:
// FSM state encoding, battery width/limits and the per-load drain cost.
package energy_pkg;

    localparam int BAT_W      = 14;
    localparam int CAP        = 9999;
    localparam int LOW_THRESH = 100;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_CHARGE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_ON     = 2'd3
    } em_state_t;

    // Drain per tick doubles with each load class.
    function automatic logic [3:0] load_cost(input logic [1:0] load);
        logic [3:0] cost;
        case (load)
            2'd0:    cost = 4'd1;
            2'd1:    cost = 4'd2;
            2'd2:    cost = 4'd4;
            default: cost = 4'd8;
        endcase
        return cost;
    endfunction

endpackage

// File: rtl/energy_manager_tick_gen.sv
// Free-running divider that emits a one-cycle tick every TICK_DIV enabled
// cycles; held at zero while disabled or cleared.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr || !en) begin
            cnt_reg <= '0;
        end else if (cnt_reg == LAST) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt_reg == LAST);

endmodule

// File: rtl/energy_manager.sv
// Battery controller: arbitrates charge sessions (unit off) against running
// (unit on), commits keypad charge entries and drains by load while on.
module energy_manager
    import energy_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int CAP        = energy_pkg::CAP,
    parameter int LOW_THRESH = energy_pkg::LOW_THRESH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             power_key,
    input  logic             charge_req,
    input  logic [9:0]       charge_amount,
    input  logic             charge_done,
    input  logic [1:0]       load,
    output logic             on,
    output logic             charge_en,
    output logic             entry_rst_n,
    output logic [BAT_W-1:0] battery,
    output logic             low_warn,
    output logic             empty,
    output logic [1:0]       state
);

    em_state_t        state_reg, state_next;
    logic [BAT_W-1:0] battery_reg, battery_next;
    logic             key_q_reg, done_q_reg;
    logic             key_rise, done_rise;
    logic             tick;
    logic [BAT_W:0]   charge_sum;
    logic [BAT_W-1:0] drain_val;
    logic [BAT_W-1:0] cost_ext;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (state_reg != ST_ON),
        .en  (state_reg == ST_ON),
        .tick(tick)
    );

    // Edge detectors track inputs continuously, so a level already high on
    // entry to a state never counts as a fresh edge.
    assign key_rise  = power_key & ~key_q_reg;
    assign done_rise = charge_done & ~done_q_reg;

    assign cost_ext   = BAT_W'(load_cost(load));
    assign charge_sum = {1'b0, battery_reg} + (BAT_W + 1)'(charge_amount);
    assign drain_val  = (battery_reg > cost_ext) ? (battery_reg - cost_ext) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_OFF;
            battery_reg <= '0;
            key_q_reg   <= 1'b0;
            done_q_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            battery_reg <= battery_next;
            key_q_reg   <= power_key;
            done_q_reg  <= charge_done;
        end
    end

    always_comb begin
        state_next   = state_reg;
        battery_next = battery_reg;
        case (state_reg)
            ST_OFF: begin
                if (charge_req) begin
                    state_next = ST_CHARGE;
                end else if (key_rise && (battery_reg != '0)) begin
                    state_next = ST_ON;
                end
            end
            ST_CHARGE: begin
                if (!charge_req) begin
                    state_next = ST_OFF;
                end else if (done_rise) begin
                    if (charge_sum > (BAT_W + 1)'(CAP)) begin
                        battery_next = BAT_W'(CAP);
                    end else begin
                        battery_next = charge_sum[BAT_W-1:0];
                    end
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!charge_req) begin
                    state_next = ST_OFF;
                end
            end
            ST_ON: begin
                // A tick coinciding with the key still drains before switching off.
                if (tick) begin
                    battery_next = drain_val;
                    if (key_rise || (drain_val == '0)) begin
                        state_next = ST_OFF;
                    end
                end else if (key_rise) begin
                    state_next = ST_OFF;
                end
            end
            default: begin
                state_next = ST_OFF;
            end
        endcase
    end

    assign on          = (state_reg == ST_ON);
    assign charge_en   = (state_reg == ST_CHARGE);
    assign entry_rst_n = (state_reg == ST_CHARGE);
    assign battery     = battery_reg;
    assign low_warn    = (battery_reg < BAT_W'(LOW_THRESH));
    assign empty       = (battery_reg == '0);
    assign state       = state_reg;

endmodule
